// File: rtl/walk_sequencer.sv
// Tile-stepping walk sequencer for a sprite character: turn-in-place, walk, and bump-into-wall poses,
// advanced one frame per Frame_Tick.
module walk_sequencer #(
  parameter int unsigned STEP_PIXELS = 16,
  parameter int unsigned TURN_FRAMES = 4,
  parameter logic [9:0]  START_X     = 10'd292,
  parameter logic [9:0]  START_Y     = 10'd350,
  parameter logic [9:0]  MAX_X       = 10'd623,
  parameter logic [9:0]  MAX_Y       = 10'd456
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Frame_Tick,
  input  logic       Key_Valid,
  input  logic [1:0] Key_Dir,
  input  logic       Blocked,
  output logic [1:0] Direction,
  output logic       Character_Moving,
  output logic [1:0] Anim_Frame,
  output logic [9:0] Pos_X,
  output logic [9:0] Pos_Y,
  output logic       Step_Done
);

  typedef enum logic [1:0] {StIdle, StTurn, StWalk, StBump} state_e;

  localparam logic [5:0] STEP_LAST = 6'(STEP_PIXELS - 1);
  localparam logic [5:0] HALF_STEP = 6'(STEP_PIXELS / 2);
  localparam logic [5:0] TURN_LAST = 6'(TURN_FRAMES - 1);
  localparam logic [9:0] STEP_W    = 10'(STEP_PIXELS);

  state_e     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic       r_foot, w_foot_nxt;
  logic [1:0] r_dir, w_dir_nxt;
  logic [9:0] r_pos_x, w_pos_x_nxt;
  logic [9:0] r_pos_y, w_pos_y_nxt;
  logic       r_step_done, w_step_done_nxt;
  logic       w_edge;
  logic       w_chain;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_foot      <= 1'b0;
      r_dir       <= 2'd2;
      r_pos_x     <= START_X;
      r_pos_y     <= START_Y;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_foot      <= w_foot_nxt;
      r_dir       <= w_dir_nxt;
      r_pos_x     <= w_pos_x_nxt;
      r_pos_y     <= w_pos_y_nxt;
      r_step_done <= w_step_done_nxt;
    end
  end

  // Position after this tick's move; the edge check looks at where the character will stand,
  // so a chained step can never carry Pos past the playfield limits.
  always_comb begin
    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    if (Frame_Tick && (r_state == StWalk)) begin
      unique case (r_dir)
        2'd0: w_pos_y_nxt = r_pos_y - 10'd1;
        2'd1: w_pos_x_nxt = r_pos_x + 10'd1;
        2'd2: w_pos_y_nxt = r_pos_y + 10'd1;
        2'd3: w_pos_x_nxt = r_pos_x - 10'd1;
      endcase
    end
  end

  always_comb begin
    w_edge = 1'b0;
    unique case (Key_Dir)
      2'd0: w_edge = (w_pos_y_nxt < STEP_W);
      2'd1: w_edge = (w_pos_x_nxt > (MAX_X - STEP_W));
      2'd2: w_edge = (w_pos_y_nxt > (MAX_Y - STEP_W));
      2'd3: w_edge = (w_pos_x_nxt < STEP_W);
    endcase
  end

  assign w_chain = Key_Valid && (Key_Dir == r_dir) && !Blocked && !w_edge;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_foot_nxt      = r_foot;
    w_dir_nxt       = r_dir;
    w_step_done_nxt = 1'b0;
    if (Frame_Tick) begin
      unique case (r_state)
        StIdle: begin
          if (Key_Valid) begin
            w_cnt_nxt = '0;
            if (Key_Dir != r_dir) begin
              w_dir_nxt   = Key_Dir;
              w_state_nxt = StTurn;
            end else begin
              w_state_nxt = (w_edge || Blocked) ? StBump : StWalk;
            end
          end
        end
        StTurn: begin
          if (r_cnt == TURN_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
        StWalk: begin
          if (r_cnt == STEP_LAST) begin
            w_step_done_nxt = 1'b1;
            w_foot_nxt      = ~r_foot;
            w_cnt_nxt       = '0;
            w_state_nxt     = w_chain ? StWalk : StIdle;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
        StBump: begin
          if (r_cnt == STEP_LAST) begin
            w_foot_nxt  = ~r_foot;
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    Anim_Frame = 2'd0;
    unique case (r_state)
      StTurn:         Anim_Frame = r_foot ? 2'd2 : 2'd1;
      StWalk, StBump: Anim_Frame = (r_cnt < HALF_STEP) ? (r_foot ? 2'd2 : 2'd1) : 2'd0;
      default:        Anim_Frame = 2'd0;
    endcase
  end

  assign Character_Moving = (r_state == StWalk) || (r_state == StBump);
  assign Direction        = r_dir;
  assign Pos_X            = r_pos_x;
  assign Pos_Y            = r_pos_y;
  assign Step_Done        = r_step_done;

endmodule

// File: tb/tb_walk_sequencer.sv
// Scoreboard bench for walk_sequencer: each tick queues its expected outputs, a monitor pops and
// compares just after the ticked clock edge.
module tb_walk_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Frame_Tick;
  logic       Key_Valid;
  logic [1:0] Key_Dir;
  logic       Blocked;
  logic [1:0] Direction;
  logic       Character_Moving;
  logic [1:0] Anim_Frame;
  logic [9:0] Pos_X;
  logic [9:0] Pos_Y;
  logic       Step_Done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit         care;
    string      tag;
    logic [1:0] dir;
    logic       mv;
    logic [1:0] anim;
    logic [9:0] px;
    logic [9:0] py;
    logic       sd;
  } exp_t;

  exp_t sb_q[$];

  walk_sequencer dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Frame_Tick       (Frame_Tick),
    .Key_Valid        (Key_Valid),
    .Key_Dir          (Key_Dir),
    .Blocked          (Blocked),
    .Direction        (Direction),
    .Character_Moving (Character_Moving),
    .Anim_Frame       (Anim_Frame),
    .Pos_X            (Pos_X),
    .Pos_Y            (Pos_Y),
    .Step_Done        (Step_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] dir, input logic mv,
                          input logic [1:0] anim, input logic [9:0] px, input logic [9:0] py,
                          input logic sd);
    chk({tag, ".dir"},  int'(Direction),        int'(dir));
    chk({tag, ".mv"},   int'(Character_Moving), int'(mv));
    chk({tag, ".anim"}, int'(Anim_Frame),       int'(anim));
    chk({tag, ".px"},   int'(Pos_X),            int'(px));
    chk({tag, ".py"},   int'(Pos_Y),            int'(py));
    chk({tag, ".sd"},   int'(Step_Done),        int'(sd));
  endtask

  // One Frame_Tick with its expected post-edge outputs queued for the monitor.
  task automatic tick(input string tag, input logic kv, input logic [1:0] kd, input logic blk,
                      input bit care, input logic [1:0] dir, input logic mv,
                      input logic [1:0] anim, input logic [9:0] px, input logic [9:0] py,
                      input logic sd);
    exp_t e;
    @(negedge Clk);
    Key_Valid  = kv;
    Key_Dir    = kd;
    Blocked    = blk;
    Frame_Tick = 1'b1;
    e.care = care; e.tag = tag; e.dir = dir; e.mv = mv; e.anim = anim;
    e.px = px; e.py = py; e.sd = sd;
    sb_q.push_back(e);
    @(negedge Clk);
    Frame_Tick = 1'b0;
  endtask

  // Monitor: ticked edges pop the scoreboard; unticked edges must leave Step_Done low.
  always begin
    @(posedge Clk);
    if (Reset) begin
      if (Frame_Tick) begin
        #1;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard: got output with empty queue, expected a queued entry");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.care) chk_outs(e.tag, e.dir, e.mv, e.anim, e.px, e.py, e.sd);
        end
      end else begin
        #1;
        chk("idle_step_done", int'(Step_Done), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] a;
    logic [9:0] y;
    Reset      = 1'b0;
    Frame_Tick = 1'b0;
    Key_Valid  = 1'b0;
    Key_Dir    = 2'd0;
    Blocked    = 1'b0;
    repeat (3) @(negedge Clk);
    chk_outs("reset", 2'd2, 1'b0, 2'd0, 10'd292, 10'd350, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);

    // Hold down: one IDLE tick, then two chained steps; released on the last completing tick.
    for (int k = 1; k <= 33; k++) begin
      if (k == 1) y = 10'd350; else y = 10'(349 + k);
      if (k == 1)       a = 2'd1;
      else if (k <= 16) a = (k - 1 < 8) ? 2'd1 : 2'd0;
      else if (k == 17) a = 2'd2;
      else if (k <= 32) a = (k - 17 < 8) ? 2'd2 : 2'd0;
      else              a = 2'd0;
      tick($sformatf("walk%0d", k), k < 33, 2'd2, 1'b0, 1'b1, 2'd2, k != 33, a, 10'd292, y,
           (k == 17) || (k == 33));
    end

    // Turn right; keys pressed during the turn are ignored.
    tick("turn1", 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 10'd292, 10'd382, 1'b0);
    for (int k = 2; k <= 4; k++)
      tick($sformatf("turn%0d", k), 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 10'd292, 10'd382,
           1'b0);
    tick("turn5", 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 10'd292, 10'd382, 1'b0);
    tick("turn6", 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 10'd292, 10'd382, 1'b0);

    // Face up, then bump into a blocked tile.
    tick("tup1", 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 10'd292, 10'd382, 1'b0);
    for (int k = 2; k <= 5; k++)
      tick($sformatf("tup%0d", k), 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, (k < 5) ? 2'd1 : 2'd0,
           10'd292, 10'd382, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      if (k == 1)       a = 2'd1;
      else if (k <= 16) a = (k - 1 < 8) ? 2'd1 : 2'd0;
      else              a = 2'd0;
      tick($sformatf("bump%0d", k), 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, k < 17, a, 10'd292, 10'd382,
           1'b0);
    end

    // Walk up 23 chained steps to the top edge (382 -> 14), stopping on the edge check.
    for (int k = 1; k <= 369; k++) begin
      if (k == 17)
        tick("up17", 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 10'd292, 10'd366, 1'b1);
      else if (k == 369)
        tick("up369", 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 10'd292, 10'd14, 1'b1);
      else
        tick("up", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
    end
    for (int k = 1; k <= 17; k++) begin
      if (k == 1)       a = 2'd1;
      else if (k <= 16) a = (k - 1 < 8) ? 2'd1 : 2'd0;
      else              a = 2'd0;
      tick($sformatf("edge%0d", k), 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, k < 17, a, 10'd292, 10'd14,
           1'b0);
    end

    // Turn down (Foot=1 now), walk to Cnt=7, then reset mid-step.
    tick("tdn1", 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 10'd292, 10'd14, 1'b0);
    for (int k = 2; k <= 5; k++)
      tick($sformatf("tdn%0d", k), 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, (k < 5) ? 2'd2 : 2'd0,
           10'd292, 10'd14, 1'b0);
    for (int k = 1; k <= 8; k++)
      tick($sformatf("dn%0d", k), 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 10'd292,
           (k == 1) ? 10'd14 : 10'(13 + k), 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk_outs("async_rst", 2'd2, 1'b0, 2'd0, 10'd292, 10'd350, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      Frame_Tick = 1'b1;
      Key_Valid  = 1'b1;
      Key_Dir    = 2'd1;
      @(negedge Clk);
      Frame_Tick = 1'b0;
    end
    chk_outs("rst_ticks", 2'd2, 1'b0, 2'd0, 10'd292, 10'd350, 1'b0);
    Reset = 1'b1;
    tick("post_rst", 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 10'd292, 10'd350, 1'b0);

    repeat (4) @(negedge Clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
